// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
// -----------------
// Sequencing controller for a SHA-256 compression datapath. It accepts one
// 512-bit block per start handshake and then drives the select and enable
// conditions for the hash-state registers (H0..H7), the working registers
// (a..h) and the message schedule. It walks through INIT, ROUNDS compression
// rounds, the feed-forward UPDATE and a one-cycle DONE. The controller owns
// no data words; it only steers the mux-registers in the datapath.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-low reset
//   start_i         block available; accepted when start_i && ready_o
//   first_i         sampled at accept: first block of a message (H <- IV)
//   last_i          sampled at accept: last block of a message
//   abort_i         synchronous abort back to IDLE (priority over start_i)
//   ready_o         idle, a block can be accepted
//   busy_o          high in INIT, ROUND and UPDATE
//   iv_sel_o        1: IV is the source for H and a..h, 0: H registers
//   h_en_o          H register load enable
//   h_add_sel_o     H mux select, 1: H + work feed-forward, 0: IV/H source
//   work_en_o       a..h load enable
//   work_sel_o      a..h mux select, 1: init from source, 0: round result
//   w_sel_o         1: W[t] from message word, 0: computed schedule word
//   w_shift_o       advance the 16-word schedule window
//   round_o         current round index t (K[t] lookup)
//   done_o          one-cycle pulse when a block completes
//   digest_valid_o  H holds the final digest of a message

module sha256_round_ctrl #(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16,
  parameter int IDX_W     = $clog2(ROUNDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             iv_sel_o,
  output logic             h_en_o,
  output logic             h_add_sel_o,
  output logic             work_en_o,
  output logic             work_sel_o,
  output logic             w_sel_o,
  output logic             w_shift_o,
  output logic [IDX_W-1:0] round_o,
  output logic             done_o,
  output logic             digest_valid_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ROUND  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] MSG_LIMIT  = IDX_W'(MSG_WORDS);

  state_t           state_reg;
  logic [IDX_W-1:0] round_reg;
  logic             first_reg;
  logic             last_reg;
  logic             digest_valid_reg;

  // All sequencing state lives here; every output is a pure decode of it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg        <= IDLE;
      round_reg        <= '0;
      first_reg        <= 1'b0;
      last_reg         <= 1'b0;
      digest_valid_reg <= 1'b0;
    end else if (abort_i) begin
      // Abort wins over start, including in IDLE where it only clears
      // the digest flag (state and counter are already at rest there).
      state_reg        <= IDLE;
      round_reg        <= '0;
      digest_valid_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start_i) begin
            first_reg        <= first_i;
            last_reg         <= last_i;
            digest_valid_reg <= 1'b0;
            round_reg        <= '0;
            state_reg        <= INIT;
          end
        end
        INIT: begin
          state_reg <= ROUND;
        end
        ROUND: begin
          // Explicit clear on the final round so the counter never relies
          // on natural wrap (ROUNDS need not be a power of two).
          if (round_reg == LAST_ROUND) begin
            round_reg <= '0;
            state_reg <= UPDATE;
          end else begin
            round_reg <= round_reg + IDX_W'(1);
          end
        end
        UPDATE: begin
          state_reg <= DONE;
        end
        DONE: begin
          if (last_reg) begin
            digest_valid_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          round_reg <= '0;
        end
      endcase
    end
  end

  // Moore decode of state and round counter.
  always_comb begin
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    iv_sel_o    = 1'b0;
    h_en_o      = 1'b0;
    h_add_sel_o = 1'b0;
    work_en_o   = 1'b0;
    work_sel_o  = 1'b0;
    w_sel_o     = 1'b0;
    w_shift_o   = 1'b0;
    done_o      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
      end
      INIT: begin
        busy_o     = 1'b1;
        work_en_o  = 1'b1;
        work_sel_o = 1'b1;
        // Only the first block of a message seeds H from the IV; later
        // blocks start a..h from the chained H values.
        iv_sel_o   = first_reg;
        h_en_o     = first_reg;
      end
      ROUND: begin
        busy_o    = 1'b1;
        work_en_o = 1'b1;
        w_shift_o = 1'b1;
        w_sel_o   = (round_reg < MSG_LIMIT);
      end
      UPDATE: begin
        busy_o      = 1'b1;
        h_en_o      = 1'b1;
        h_add_sel_o = 1'b1;
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
        ready_o = 1'b0;
      end
    endcase
  end

  assign round_o        = round_reg;
  assign digest_valid_o = digest_valid_reg;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl. The reference model tracks a
// block as "cycles elapsed since accept" and derives every expected output
// from the block timeline (INIT at +1, rounds at +2..+65, UPDATE at +66,
// DONE at +67, back to idle at +68).

module tb_sha256_round_ctrl;

  localparam int ROUNDS    = 64;
  localparam int MSG_WORDS = 16;
  localparam int IDX_W     = 6;
  localparam int BLOCK_LEN = ROUNDS + 4;   // accept-to-ready period

  logic             clk_i   = 1'b0;
  logic             rst_i   = 1'b0;
  logic             start_i = 1'b0;
  logic             first_i = 1'b0;
  logic             last_i  = 1'b0;
  logic             abort_i = 1'b0;
  logic             ready_o;
  logic             busy_o;
  logic             iv_sel_o;
  logic             h_en_o;
  logic             h_add_sel_o;
  logic             work_en_o;
  logic             work_sel_o;
  logic             w_sel_o;
  logic             w_shift_o;
  logic [IDX_W-1:0] round_o;
  logic             done_o;
  logic             digest_valid_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit ref_active = 1'b0;
  int ref_phase  = 0;      // cycles since accept while active
  bit ref_first  = 1'b0;
  bit ref_last   = 1'b0;
  bit ref_dv     = 1'b0;

  always #5 clk_i = ~clk_i;

  sha256_round_ctrl #(
    .ROUNDS    (ROUNDS),
    .MSG_WORDS (MSG_WORDS),
    .IDX_W     (IDX_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .first_i        (first_i),
    .last_i         (last_i),
    .abort_i        (abort_i),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .iv_sel_o       (iv_sel_o),
    .h_en_o         (h_en_o),
    .h_add_sel_o    (h_add_sel_o),
    .work_en_o      (work_en_o),
    .work_sel_o     (work_sel_o),
    .w_sel_o        (w_sel_o),
    .w_shift_o      (w_shift_o),
    .round_o        (round_o),
    .done_o         (done_o),
    .digest_valid_o (digest_valid_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at t=%0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    ref_active = 1'b0;
    ref_phase  = 0;
    ref_first  = 1'b0;
    ref_last   = 1'b0;
    ref_dv     = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic model_step();
    if (abort_i) begin
      if (ref_active)
        $display("[TB] abort at phase %0d", ref_phase);
      ref_active = 1'b0;
      ref_phase  = 0;
      ref_dv     = 1'b0;
    end else if (!ref_active) begin
      if (start_i) begin
        ref_active = 1'b1;
        ref_phase  = 1;
        ref_first  = first_i;
        ref_last   = last_i;
        ref_dv     = 1'b0;
      end
    end else begin
      ref_phase++;
      if (ref_phase == BLOCK_LEN) begin
        ref_active = 1'b0;
        ref_phase  = 0;
        if (ref_last) ref_dv = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    int  p;
    bit  in_round;
    logic [31:0] exp_round;
    p         = ref_active ? ref_phase : 0;
    in_round  = ref_active && (p >= 2) && (p <= ROUNDS + 1);
    exp_round = in_round ? 32'(p - 2) : 32'd0;
    check_eq({ctx, ":ready"},     32'(ready_o),        32'(!ref_active));
    check_eq({ctx, ":busy"},      32'(busy_o),         32'(ref_active && p <= ROUNDS + 2));
    check_eq({ctx, ":iv_sel"},    32'(iv_sel_o),       32'(ref_active && p == 1 && ref_first));
    check_eq({ctx, ":h_en"},      32'(h_en_o),         32'(ref_active && ((p == 1 && ref_first) || p == ROUNDS + 2)));
    check_eq({ctx, ":h_add_sel"}, 32'(h_add_sel_o),    32'(ref_active && p == ROUNDS + 2));
    check_eq({ctx, ":work_en"},   32'(work_en_o),      32'(ref_active && p >= 1 && p <= ROUNDS + 1));
    check_eq({ctx, ":work_sel"},  32'(work_sel_o),     32'(ref_active && p == 1));
    check_eq({ctx, ":w_sel"},     32'(w_sel_o),        32'(in_round && (p - 2) < MSG_WORDS));
    check_eq({ctx, ":w_shift"},   32'(w_shift_o),      32'(in_round));
    check_eq({ctx, ":round"},     32'(round_o),        exp_round);
    check_eq({ctx, ":done"},      32'(done_o),         32'(ref_active && p == ROUNDS + 3));
    check_eq({ctx, ":dv"},        32'(digest_valid_o), 32'(ref_dv));
  endtask

  // One clock cycle: drive inputs, take the edge, check at the falling edge.
  task automatic run_cycle(input bit s, input bit f, input bit l, input bit a, input string ctx);
    start_i = s;
    first_i = f;
    last_i  = l;
    abort_i = a;
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_outputs(ctx);
    if (ref_active && ref_phase == ROUNDS + 3)
      $display("[TB] block done first=%0b last=%0b", ref_first, ref_last);
  endtask

  // Idle-run until the model reaches a given phase; bounded.
  task automatic run_to_phase(input int target, input string ctx);
    int guard = 0;
    while (!(ref_active && ref_phase == target) && guard < 2 * BLOCK_LEN) begin
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, ctx);
      guard++;
    end
    if (guard >= 2 * BLOCK_LEN)
      check_eq({ctx, ":wait_bound"}, 32'(guard), 32'(2 * BLOCK_LEN - 1));
  endtask

  task automatic run_block(input bit f, input bit l, input string ctx);
    run_cycle(1'b1, f, l, 1'b0, ctx);
    for (int i = 0; i < BLOCK_LEN; i++)
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, ctx);
  endtask

  // Called just after a falling-edge check: assert reset mid-cycle and
  // confirm the outputs fall to reset values without waiting for an edge.
  task automatic async_reset(input string ctx);
    #2 rst_i = 1'b0;
    model_reset();
    #1 check_outputs({ctx, ":async"});
    repeat (2) @(negedge clk_i);
    check_outputs({ctx, ":hold"});
    rst_i = 1'b1;
  endtask

  initial begin
    // Power-on reset
    #1 check_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    check_outputs("reset_rel");

    // Single-block message
    run_block(1'b1, 1'b1, "single");

    // Two-block message
    run_block(1'b1, 1'b0, "two_b1");
    run_block(1'b0, 1'b1, "two_b2");

    // start_i held high: accepts only from IDLE
    for (int i = 0; i < 2 * BLOCK_LEN + 5; i++)
      run_cycle(1'b1, i[0], 1'b1, 1'b0, "start_held");
    run_to_phase(ROUNDS + 3, "drain");
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, "drain");

    // Abort at round 30, then a clean full run
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, "abort");
    run_to_phase(30 + 2, "abort");
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, "abort_cyc");
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, "abort_after");
    run_block(1'b1, 1'b1, "after_abort");

    // Asynchronous reset at round 40, restart on the first edge after release
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, "rst_mid");
    run_to_phase(40 + 2, "rst_mid");
    async_reset("rst_mid");
    run_block(1'b1, 1'b1, "after_rst");

    // abort and start together in IDLE with a valid digest
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, "abort_start_idle");
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, "abort_start_idle");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      run_cycle(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 149) == 0), "rand");
      if ($urandom_range(0, 1499) == 0)
        async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. It accepts one 512-bit message block per handshake, then drives the mux-select and load-enable conditions of the hash-state registers (H0..H7) and working registers (a..h) through init, 64 rounds and the final feed-forward add. It also drives the message-schedule select and round index, and flags a valid digest after the last block of a message. It owns no data; the datapath built from synchronous mux-registers holds all words.

## Interface

- ROUNDS, 64: compression rounds per block.
- MSG_WORDS, 16: rounds that take W[t] directly from the message block.
- IDX_W, 6: width of round_o, equal to $clog2(ROUNDS).

- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  block available; accepted when start_i && ready_o.
- first_i  in  1  sampled at accept; block is the first of a message, so H is loaded from the IV.
- last_i  in  1  sampled at accept; block is the last of a message.
- abort_i  in  1  synchronous abort; returns to IDLE.
- ready_o  out  1  controller idle, can accept a block.
- busy_o  out  1  high in INIT, ROUND and UPDATE.
- iv_sel_o  out  1  1 selects the IV as the source for H and a..h; 0 selects the H registers.
- h_en_o  out  1  H register load enable.
- h_add_sel_o  out  1  H mux select: 1 is H+work feed-forward, 0 is the IV or H source.
- work_en_o  out  1  a..h load enable.
- work_sel_o  out  1  a..h mux select: 1 is init from the source, 0 is the round-function result.
- w_sel_o  out  1  1 takes W[t] from the message word, 0 takes the computed schedule word.
- w_shift_o  out  1  advance the 16-word schedule window.
- round_o  out  IDX_W  current round index t, used for K[t] lookup.
- done_o  out  1  one-cycle pulse when block processing completes.
- digest_valid_o  out  1  H holds the final digest of a message.

## Operation

- States are IDLE, INIT, ROUND, UPDATE and DONE. State, round counter, first_q, last_q and digest_valid are flops. All other outputs decode from the state and counter (Moore-style).
- **IDLE**
  - ready_o=1; all enables are 0.
  - On accept: capture first_q and last_q, clear digest_valid_o, clear the counter, go to INIT.
  - start_i without ready_o is ignored and never queued.
- **INIT** (1 cycle)
  - work_en_o=1, work_sel_o=1, iv_sel_o=first_q.
  - h_en_o=first_q, with h_add_sel_o=0, so H loads the IV only on the first block.
  - Go to ROUND.
- **ROUND** (ROUNDS cycles)
  - work_en_o=1, work_sel_o=0, w_shift_o=1.
  - w_sel_o=(round_o < MSG_WORDS).
  - round_o=t counts 0..ROUNDS-1.
  - When t==ROUNDS-1, go to UPDATE and clear the counter. The counter never wraps silently.
- **UPDATE** (1 cycle)
  - h_en_o=1, h_add_sel_o=1, iv_sel_o=0.
  - Go to DONE.
- **DONE** (1 cycle)
  - done_o=1.
  - digest_valid_o is set at the DONE→IDLE edge if last_q.
  - Go to IDLE.
- digest_valid_o holds until the next accepted start, abort or reset.
- **abort_i**, sampled in any non-IDLE state:
  - Next state is IDLE, the counter clears and digest_valid_o clears.
  - No done_o pulse.
  - In the abort cycle, enables still follow the current state, so H contents are undefined for the datapath after an abort.
  - abort_i in IDLE clears digest_valid_o only.
- abort_i has priority over start_i in the same cycle. The start is not accepted.
- Reset values: state=IDLE, round_o=0, digest_valid_o=0, first_q=0, last_q=0. Hence ready_o=1 and every other output is 0.

## Timing

- Accept at edge T (IDLE, start_i=1).
  - INIT during cycle T+1.
  - ROUND t=0..63 during T+2..T+65.
  - UPDATE at T+66.
  - DONE (done_o=1) at T+67.
  - ready_o=1 again at T+68.
- Block latency is 67 cycles from accept to done_o. Throughput is one block per 68 cycles.
- w_sel_o is high for t=0..15 (cycles T+2..T+17) and low for t=16..63.
- digest_valid_o rises at T+68, coincident with ready_o.
- Reset asserted mid-operation forces IDLE immediately, asynchronously. The first accept is possible on the first edge after rst_i deasserts.

## Test plan

- **Single-block message** (first_i=1, last_i=1, start at T):
  - h_en_o=1 with h_add_sel_o=0 at T+1.
  - round_o steps 0..63 over T+2..T+65.
  - w_sel_o is high exactly 16 cycles.
  - h_add_sel_o=1 at T+66, done_o at T+67.
  - digest_valid_o=1 from T+68.
- **Two-block message** (first=1,last=0, then first=0,last=1):
  - Block 1: h_en_o=1 in INIT, digest_valid_o stays 0 after the first done_o.
  - Block 2: h_en_o=0 in INIT, iv_sel_o=0, digest_valid_o=1 after the second done_o.
- **start_i held high throughout:**
  - Accepts only in IDLE, every 68 cycles.
  - No accept in INIT, ROUND, UPDATE or DONE.
  - busy_o is low only in IDLE and DONE.
- **abort_i at round_o=30:**
  - Next cycle is IDLE with ready_o=1 and round_o=0.
  - No done_o; digest_valid_o=0.
  - A subsequent start yields a full 67-cycle run.
- **rst_i asserted at round_o=40:**
  - All outputs take reset values asynchronously.
  - Restart after release gives correct round_o 0..63.
- **abort_i and start_i together in IDLE with digest_valid_o=1:** no accept, and digest_valid_o clears.
